// File: rtl/byte_invert_fifo.sv
// Elastic byte buffer: stores ~in_data (or in_data when bypass_inv=1) in a small
// circular FIFO, with occupancy and an output-transfer counter.
module byte_invert_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     bypass_inv,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         xfer_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic             push;
    logic             pop;

    // Valid/ready: a transfer happens on a posedge where both are 1. in_ready
    // and out_valid depend only on rst, flush and stored state, never on the
    // partner's valid/ready, so there is no combinational path through the stage.
    assign in_ready  = !rst && !flush && (level_q < FULL_LVL);
    assign out_valid = !rst && !flush && (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = rst ? '0 : level_q;
    assign xfer_cnt  = rst ? '0 : xfer_cnt_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        xfer_cnt_d = xfer_cnt_q;

        // The transform is applied once, at write time.
        if (push) begin
            mem_d[wr_ptr_q] = bypass_inv ? in_data : ~in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase

        // Flush blocks both handshakes, so only occupancy state needs clearing.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            xfer_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_byte_invert_fifo.sv
// Directed bench for byte_invert_fifo: a hand-computed vector table followed by
// model-checked sequences for wrap, flush, mid-stream reset and counter wrap.
module tb_byte_invert_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             bypass_inv;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [2:0]       level;
    logic [CNT_W-1:0] xfer_cnt;

    byte_invert_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bypass_inv (bypass_inv),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .xfer_cnt   (xfer_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]       exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       byp;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_lvl;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic f, input logic b, input logic iv,
                                input logic [7:0] id, input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [7:0] e_od, input logic [2:0] e_lvl,
                                input logic [3:0] e_cnt);
        vec_t v;
        v.rst = r; v.flush = f; v.byp = b; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = e_lvl; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic b, input logic iv,
                         input logic [7:0] d, input logic ordy);
        @(negedge clk);
        rst = r; flush = f; bypass_inv = b; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
    endtask

    // Model-checked cycle: compare outputs against the scoreboard, then advance it.
    task automatic step(input logic r, input logic f, input logic b, input logic iv,
                        input logic [7:0] d, input logic ordy);
        logic e_ir, e_ov;
        drive(r, f, b, iv, d, ordy);
        e_ir = !r && !f && (exp_q.size() < DEPTH);
        e_ov = !r && !f && (exp_q.size() != 0);
        chk("in_ready", in_ready, e_ir);
        chk("out_valid", out_valid, e_ov);
        if (e_ov) chk("out_data", out_data, exp_q[0]);
        chk("level", level, r ? 16'd0 : exp_q.size());
        chk("xfer_cnt", xfer_cnt, r ? 16'd0 : exp_cnt);
        if (r) begin
            exp_q.delete();
            exp_cnt = '0;
        end else if (f) begin
            exp_q.delete();
        end else begin
            if (e_ov && ordy) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 1'b1;
            end
            if (e_ir && iv) exp_q.push_back(b ? d : ~d);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; bypass_inv = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; out_ready = 1'b0;
        exp_cnt = '0;

        //   rst f  byp iv  id     ordy ir ov od     lvl cnt
        // reset held 3 cycles, then release
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        // single byte 3C -> C3
        add(0, 0, 0, 1, 8'h3C, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hC3, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 1);
        // fill with 00..04 under backpressure, 04 held while full
        add(0, 0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0, 1);
        add(0, 0, 0, 1, 8'h01, 0, 1, 1, 8'hFF, 1, 1);
        add(0, 0, 0, 1, 8'h02, 0, 1, 1, 8'hFF, 2, 1);
        add(0, 0, 0, 1, 8'h03, 0, 1, 1, 8'hFF, 3, 1);
        add(0, 0, 0, 1, 8'h04, 0, 0, 1, 8'hFF, 4, 1);
        add(0, 0, 0, 1, 8'h04, 0, 0, 1, 8'hFF, 4, 1);
        // release backpressure: pop while full, then 04 enters
        add(0, 0, 0, 1, 8'h04, 1, 0, 1, 8'hFF, 4, 1);
        add(0, 0, 0, 1, 8'h04, 1, 1, 1, 8'hFE, 3, 2);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hFD, 3, 3);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hFC, 2, 4);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hFB, 1, 5);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 6);
        // bypass toggling: A5 stored raw, then inverted
        add(0, 0, 1, 1, 8'hA5, 0, 1, 0, 8'h00, 0, 6);
        add(0, 0, 0, 1, 8'hA5, 0, 1, 1, 8'hA5, 1, 6);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hA5, 2, 6);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h5A, 1, 7);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].byp, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_od);
            chk($sformatf("v%0d_level", i), level, vecs[i].e_lvl);
            chk($sformatf("v%0d_xfer_cnt", i), xfer_cnt, vecs[i].e_cnt);
        end

        exp_q.delete();
        exp_cnt = 4'd8;

        // simultaneous push/pop at level 2 for 10 cycles, pointers wrap
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 8'h10 + 8'(i), 0);
        for (int i = 2; i < 12; i++) begin
            step(0, 0, i[0], 1, 8'h10 + 8'(i), 1);
            chk("steady_level", level, 16'd2);
        end
        step(0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 0);

        // flush at level 3 discards entries, keeps the counter
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h40 + 8'(i), 0);
        step(0, 1, 0, 1, 8'h77, 1);
        step(0, 0, 0, 0, 8'h00, 0);
        chk("flush_cnt_kept", xfer_cnt, 16'd4);
        step(0, 0, 0, 1, 8'h81, 0);
        step(0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 0);

        // reset mid-stream drops entries; in_ready returns on the first free cycle
        step(0, 0, 1, 1, 8'h11, 0);
        step(0, 0, 1, 1, 8'h22, 0);
        step(1, 0, 0, 1, 8'h33, 1);
        step(1, 0, 0, 1, 8'h33, 1);
        step(0, 0, 0, 0, 8'h00, 0);

        // counter wrap: 17 pops from zero on a 4-bit counter
        for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 8'(i * 7), 1);
        step(0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 0);
        chk("cnt_wrap", xfer_cnt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
